// File: rtl/regfile_operand_fetch_pkg.sv
// Shared types and default widths for the register-file operand fetch block.
// Imported by the interface, the operand slot and the fetch sequencer.
package regfile_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int ADDR_W_DEF = 5;
  localparam int TAG_W_DEF  = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    CAP,
    OUT
  } fetch_state_t;

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Request, register-file, snoop and result signals of the operand fetch block.
// The sequencer takes the slave view; the surrounding pipeline takes master.
interface regfile_operand_fetch_if
  import regfile_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int ADDRESSWIDTH = ADDR_W_DEF,
  parameter int TAGWIDTH     = TAG_W_DEF
);

  logic                    in_valid;
  logic                    in_ready;
  logic [ADDRESSWIDTH-1:0] in_rs1;
  logic [ADDRESSWIDTH-1:0] in_rs2;
  logic [TAGWIDTH-1:0]     in_tag;

  logic [ADDRESSWIDTH-1:0] rf_source;
  logic [WIDTH-1:0]        rf_data;

  logic                    wr_en;
  logic [ADDRESSWIDTH-1:0] wr_dest;
  logic [WIDTH-1:0]        wr_data;

  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_op1;
  logic [WIDTH-1:0]        out_op2;
  logic [TAGWIDTH-1:0]     out_tag;

  modport slave (
    input  in_valid,
    input  in_rs1,
    input  in_rs2,
    input  in_tag,
    input  rf_data,
    input  wr_en,
    input  wr_dest,
    input  wr_data,
    input  out_ready,
    output in_ready,
    output rf_source,
    output out_valid,
    output out_op1,
    output out_op2,
    output out_tag
  );

  modport master (
    output in_valid,
    output in_rs1,
    output in_rs2,
    output in_tag,
    output rf_data,
    output wr_en,
    output wr_dest,
    output wr_data,
    output out_ready,
    input  in_ready,
    input  rf_source,
    input  out_valid,
    input  out_op1,
    input  out_op2,
    input  out_tag
  );

endinterface

// File: rtl/regfile_operand_slot.sv
// One operand register with its forward flag; a snooped write to the
// slot's address overrides and locks out any later register-file capture.
module rf_operand_slot
  import regfile_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int ADDRESSWIDTH = ADDR_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    snoop,
  input  logic                    capture,
  input  logic [ADDRESSWIDTH-1:0] addr,
  input  logic                    wr_en,
  input  logic [ADDRESSWIDTH-1:0] wr_dest,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [WIDTH-1:0]        rf_data,
  output logic [WIDTH-1:0]        op
);

  logic fwd;
  logic hit;

  assign hit = snoop && wr_en && (wr_dest == addr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op  <= '0;
      fwd <= 1'b0;
    end else if (clear) begin
      fwd <= 1'b0;
    end else if (hit) begin
      op  <= wr_data;
      fwd <= 1'b1;
    end else if (capture && !fwd) begin
      op  <= rf_data;
    end
  end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Sequences a two-source read through the single registered register-file
// port, forwards snooped writes, and hands the operand pair downstream.
module regfile_operand_fetch
  import regfile_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int ADDRESSWIDTH = ADDR_W_DEF,
  parameter int TAGWIDTH     = TAG_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  regfile_operand_fetch_if.slave bus
);

  fetch_state_t state;

  logic [ADDRESSWIDTH-1:0] rs1;
  logic [ADDRESSWIDTH-1:0] rs2;
  logic [TAGWIDTH-1:0]     tag;
  logic [WIDTH-1:0]        op1;
  logic [WIDTH-1:0]        op2;

  logic same;
  logic fire;
  logic accept;
  logic snoop;
  logic cap1;
  logic cap2;

  assign same   = (rs1 == rs2);
  assign fire   = (state == OUT) && bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = (state == IDLE) || fire;
  assign bus.out_valid = (state == OUT);
  assign bus.out_op1   = op1;
  assign bus.out_op2   = op2;
  assign bus.out_tag   = tag;

  // The handshake cycle itself is not snooped: the consumer already
  // sampled, and an accept in that cycle re-reads through RD1 anyway.
  assign snoop = (state == RD1) || (state == RD2) || (state == CAP)
              || ((state == OUT) && !bus.out_ready);

  assign cap1 = (state == RD2) || ((state == CAP) && same);
  assign cap2 = (state == CAP);

  always_comb begin
    bus.rf_source = rs1;
    unique case (1'b1)
      (state == RD2),
      (state == CAP): bus.rf_source = rs2;
      default:        bus.rf_source = rs1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rs1   <= '0;
      rs2   <= '0;
      tag   <= '0;
    end else begin
      if (accept) begin
        rs1 <= bus.in_rs1;
        rs2 <= bus.in_rs2;
        tag <= bus.in_tag;
      end
      unique case (state)
        IDLE: if (bus.in_valid) state <= RD1;
        RD1:  state <= same ? CAP : RD2;
        RD2:  state <= CAP;
        CAP:  state <= OUT;
        OUT:  if (fire) state <= bus.in_valid ? RD1 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  rf_operand_slot #(
    .WIDTH        (WIDTH),
    .ADDRESSWIDTH (ADDRESSWIDTH)
  ) u_slot1 (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .snoop   (snoop),
    .capture (cap1),
    .addr    (rs1),
    .wr_en   (bus.wr_en),
    .wr_dest (bus.wr_dest),
    .wr_data (bus.wr_data),
    .rf_data (bus.rf_data),
    .op      (op1)
  );

  rf_operand_slot #(
    .WIDTH        (WIDTH),
    .ADDRESSWIDTH (ADDRESSWIDTH)
  ) u_slot2 (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .snoop   (snoop),
    .capture (cap2),
    .addr    (rs2),
    .wr_en   (bus.wr_en),
    .wr_dest (bus.wr_dest),
    .wr_data (bus.wr_data),
    .rf_data (bus.rf_data),
    .op      (op2)
  );

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: register-file model, scoreboard of
// requests, directed hazard/backpressure/reset cases and a random phase.
module tb_regfile_operand_fetch;
  import regfile_pkg::*;

  localparam int W = 16;
  localparam int A = 5;
  localparam int T = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clr_rf = 1'b1;

  always #5 clock = ~clock;

  regfile_operand_fetch_if #(
    .WIDTH(W), .ADDRESSWIDTH(A), .TAGWIDTH(T)
  ) bus ();

  regfile_operand_fetch #(
    .WIDTH(W), .ADDRESSWIDTH(A), .TAGWIDTH(T)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // register file: write commits at the edge, read returns pre-write value
  logic [W-1:0] rf_mem [2**A];

  always @(posedge clock) begin
    if (clr_rf) begin
      for (int i = 0; i < 2**A; i++) rf_mem[i] <= '0;
    end else if (bus.wr_en) begin
      rf_mem[bus.wr_dest] <= bus.wr_data;
    end
    bus.rf_data <= rf_mem[bus.rf_source];
  end

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  typedef struct {
    logic [A-1:0] rs1;
    logic [A-1:0] rs2;
    logic [T-1:0] tag;
    int           acc;
    int           lat;
  } exp_t;

  exp_t q[$];
  logic prev_valid = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard: operands must equal register contents before handshake
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      q.delete();
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        chk("sb_pending_rise", q.size() != 0, 1);
        if (q.size() != 0)
          chk("latency", cyc - q[0].acc - 1, q[0].lat);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_pending_out", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sb_op1", bus.out_op1, rf_mem[e.rs1]);
          chk("sb_op2", bus.out_op2, rf_mem[e.rs2]);
          chk("sb_tag", bus.out_tag, e.tag);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.rs1 = bus.in_rs1;
        e.rs2 = bus.in_rs2;
        e.tag = bus.in_tag;
        e.acc = cyc;
        e.lat = (bus.in_rs1 == bus.in_rs2) ? 2 : 3;
        q.push_back(e);
      end
      prev_valid = bus.out_valid;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rf_write(input logic [A-1:0] a, input logic [W-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_dest = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // returns at the clock after the accept edge (DUT in RD1)
  task automatic send(input logic [A-1:0] r1, input logic [A-1:0] r2,
                      input logic [T-1:0] t, input bit rnd);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_rs1   = r1;
    bus.in_rs2   = r2;
    bus.in_tag   = t;
    for (int n = 0; n < 40 && !acc; n++) begin
      if (rnd) begin
        bus.wr_en     = ($urandom_range(0, 2) == 0);
        bus.wr_dest   = A'($urandom_range(0, 7));
        bus.wr_data   = W'($urandom);
        bus.out_ready = ($urandom_range(0, 1) == 1);
      end
      @(negedge clock);
      acc = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.wr_en    = 1'b0;
    chk("send_accept", acc, 1);
  endtask

  task automatic wait_valid(input int max);
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.out_valid && n < max) begin
      @(negedge clock);
      n++;
    end
    chk("valid_seen", bus.out_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_tag    = '0;
    bus.wr_en     = 1'b0;
    bus.wr_dest   = '0;
    bus.wr_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    clr_rf = 1'b0;
    reset  = 1'b1;

    @(negedge clock);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_op1", bus.out_op1, 0);
    chk("rst_op2", bus.out_op2, 0);
    chk("rst_tag", bus.out_tag, 0);
    chk("rst_source", bus.rf_source, 0);
    tick();

    // basic fetch
    bus.out_ready = 1'b1;
    rf_write(5'd3, 16'h1111);
    rf_write(5'd7, 16'h2222);
    send(5'd3, 5'd7, 4'd5, 1'b0);
    @(negedge clock);
    chk("src_rd1", bus.rf_source, 3);
    tick();
    @(negedge clock);
    chk("src_rd2", bus.rf_source, 7);
    tick();
    @(negedge clock);
    chk("src_cap", bus.rf_source, 7);
    tick();
    @(negedge clock);
    chk("basic_valid", bus.out_valid, 1);
    chk("basic_op1", bus.out_op1, 16'h1111);
    chk("basic_op2", bus.out_op2, 16'h2222);
    chk("basic_tag", bus.out_tag, 5);
    tick();

    // same register
    rf_write(5'd9, 16'hABCD);
    send(5'd9, 5'd9, 4'd2, 1'b0);
    wait_valid(10);
    chk("same_op1", bus.out_op1, 16'hABCD);
    chk("same_op2", bus.out_op2, 16'hABCD);
    tick();

    // write hazard during RD1
    rf_write(5'd4, 16'h0001);
    rf_write(5'd5, 16'h0055);
    send(5'd4, 5'd5, 4'd3, 1'b0);
    bus.wr_en   = 1'b1;
    bus.wr_dest = 5'd4;
    bus.wr_data = 16'hBEEF;
    tick();
    bus.wr_en = 1'b0;
    wait_valid(10);
    chk("haz_rd1_op1", bus.out_op1, 16'hBEEF);
    chk("haz_rd1_op2", bus.out_op2, 16'h0055);
    tick();

    // write hazard while stalled in OUT
    bus.out_ready = 1'b0;
    rf_write(5'd4, 16'h0001);
    send(5'd4, 5'd5, 4'd4, 1'b0);
    wait_valid(10);
    chk("haz_out_before", bus.out_op1, 16'h0001);
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_dest = 5'd4;
    bus.wr_data = 16'hBEEF;
    tick();
    bus.wr_en = 1'b0;
    @(negedge clock);
    chk("haz_out_valid", bus.out_valid, 1);
    chk("haz_out_op1", bus.out_op1, 16'hBEEF);
    tick();
    bus.out_ready = 1'b1;
    tick();

    // backpressure then back-to-back
    bus.out_ready = 1'b0;
    rf_write(5'd1, 16'h0A0A);
    rf_write(5'd2, 16'h0B0B);
    rf_write(5'd10, 16'h1010);
    rf_write(5'd11, 16'h1111);
    send(5'd1, 5'd2, 4'd6, 1'b0);
    wait_valid(10);
    tick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_op1", bus.out_op1, 16'h0A0A);
      chk("bp_op2", bus.out_op2, 16'h0B0B);
      chk("bp_tag", bus.out_tag, 6);
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_rs1   = 5'd10;
    bus.in_rs2   = 5'd11;
    bus.in_tag   = 4'd7;
    @(negedge clock);
    chk("b2b_blocked", bus.in_ready, 0);
    tick();
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("b2b_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("b2b_rd1_src", bus.rf_source, 10);
    wait_valid(10);
    chk("b2b_op1", bus.out_op1, 16'h1010);
    chk("b2b_op2", bus.out_op2, 16'h1111);
    chk("b2b_tag", bus.out_tag, 7);
    tick();

    // reset during RD2
    rf_write(5'd12, 16'h0C0C);
    rf_write(5'd13, 16'h0D0D);
    send(5'd12, 5'd13, 4'd8, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_op1", bus.out_op1, 0);
    chk("mid_rst_op2", bus.out_op2, 0);
    chk("mid_rst_tag", bus.out_tag, 0);
    chk("mid_rst_src", bus.rf_source, 0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("no_ghost", bus.out_valid, 0);
      tick();
    end
    send(5'd12, 5'd13, 4'd9, 1'b0);
    wait_valid(10);
    chk("post_rst_op1", bus.out_op1, 16'h0C0C);
    chk("post_rst_op2", bus.out_op2, 16'h0D0D);
    chk("post_rst_tag", bus.out_tag, 9);
    tick();

    // random traffic with snooped writes and random backpressure
    for (int i = 0; i < 24; i++) begin
      send(A'($urandom_range(0, 7)), A'($urandom_range(0, 7)),
           T'($urandom), 1'b1);
    end
    bus.wr_en     = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() != 0; n++) tick();
    tick();
    chk("drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
